// File: rtl/dpsk_pkg.sv
// Shared types and constants for the DPSK differential encoder.
package dpsk_pkg;

    // Encoder sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REF  = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    // Phase indices (quarter turns)
    localparam logic [1:0] PH_0   = 2'd0;
    localparam logic [1:0] PH_90  = 2'd1;
    localparam logic [1:0] PH_180 = 2'd2;
    localparam logic [1:0] PH_270 = 2'd3;

    // Gray-coded DQPSK dibit to phase increment
    function automatic logic [1:0] gray_delta(input logic [1:0] dibit);
        logic [1:0] d;
        case (dibit)
            2'b00:   d = PH_0;
            2'b01:   d = PH_90;
            2'b11:   d = PH_180;
            default: d = PH_270;
        endcase
        return d;
    endfunction

    // Full-scale signed amplitude for a given output width
    function automatic int amp(input int out_w);
        return (1 << (out_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/dpsk_phase_map.sv
// Combinational phase index -> signed I/Q constellation point.
module dpsk_phase_map
    import dpsk_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic [1:0]       phase,
    output logic [OUT_W-1:0] i_val,
    output logic [OUT_W-1:0] q_val
);

    localparam logic [OUT_W-1:0] A_POS = OUT_W'(amp(OUT_W));
    localparam logic [OUT_W-1:0] A_NEG = ~A_POS + OUT_W'(1);

    // Unit-circle lookup: 0 -> (+A,0), 1 -> (0,+A), 2 -> (-A,0), 3 -> (0,-A)
    always_comb begin
        i_val = '0;
        q_val = '0;
        case (phase)
            PH_0:    i_val = A_POS;
            PH_90:   q_val = A_POS;
            PH_180:  i_val = A_NEG;
            default: q_val = A_NEG;
        endcase
    end

endmodule

// File: rtl/dpsk_diff_encoder.sv
// DPSK differential encoder: bytes in, one differential phase symbol per
// output handshake. Each frame opens with a phase-0 reference symbol.
module dpsk_diff_encoder
    import dpsk_pkg::*;
#(
    parameter int BITS_PER_SYM = 2,
    parameter int OUT_W        = 8
) (
    input  logic             clk,
    input  logic             r,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [1:0]       out_phase,
    output logic [OUT_W-1:0] out_i,
    output logic [OUT_W-1:0] out_q,
    output logic             out_valid,
    input  logic             out_ready
);

    generate
        if (BITS_PER_SYM != 1 && BITS_PER_SYM != 2) begin : g_bad_bps
            $error("dpsk_diff_encoder: BITS_PER_SYM must be 1 or 2");
        end
    endgenerate

    localparam int         S        = 8 / BITS_PER_SYM;
    localparam logic [2:0] CNT_LAST = 3'(S - 1);

    // Phase increment for the symbol sitting in the top bits of b
    function automatic logic [1:0] sym_delta(input logic [7:0] b);
        if (BITS_PER_SYM == 1)
            return {b[7], 1'b0};
        else
            return gray_delta(b[7:6]);
    endfunction

    state_e           state_q, state_d;
    logic [7:0]       sr_q, sr_d;       // unsent bits, next symbol in MSBs
    logic [2:0]       cnt_q, cnt_d;
    logic             last_q, last_d;
    logic [1:0]       phase_q, phase_d; // accumulator doubles as out_phase
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_i_q, out_i_d;
    logic [OUT_W-1:0] out_q_q, out_q_d;
    logic [OUT_W-1:0] map_i, map_q;
    logic             rdy_c;
    logic             out_hs;

    dpsk_phase_map #(.OUT_W(OUT_W)) u_map (
        .phase (phase_d),
        .i_val (map_i),
        .q_val (map_q)
    );

    // Next-state, handshake and symbol generation
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        phase_d     = phase_q;
        out_valid_d = out_valid_q;
        out_hs      = out_valid_q && out_ready;
        rdy_c       = (state_q == ST_IDLE) || (state_q == ST_GAP) ||
                      (state_q == ST_DATA && cnt_q == CNT_LAST && out_ready && !last_q);

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sr_d        = in_data;
                    last_d      = in_last;
                    cnt_d       = '0;
                    phase_d     = PH_0;
                    out_valid_d = 1'b1;
                    state_d     = ST_REF;
                end
            end
            ST_REF: begin
                if (out_hs) begin
                    phase_d = phase_q + sym_delta(sr_q);
                    sr_d    = sr_q << BITS_PER_SYM;
                    cnt_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (out_hs) begin
                    if (cnt_q != CNT_LAST) begin
                        phase_d = phase_q + sym_delta(sr_q);
                        sr_d    = sr_q << BITS_PER_SYM;
                        cnt_d   = cnt_q + 3'd1;
                    end else if (last_q) begin
                        phase_d     = PH_0;
                        out_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end else if (in_valid) begin
                        // Next byte follows with no bubble
                        phase_d = phase_q + sym_delta(in_data);
                        sr_d    = in_data << BITS_PER_SYM;
                        last_d  = in_last;
                        cnt_d   = '0;
                    end else begin
                        out_valid_d = 1'b0;
                        state_d     = ST_GAP;
                    end
                end
            end
            default: begin // ST_GAP: phase held until the frame resumes
                if (in_valid) begin
                    phase_d     = phase_q + sym_delta(in_data);
                    sr_d        = in_data << BITS_PER_SYM;
                    last_d      = in_last;
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                    state_d     = ST_DATA;
                end
            end
        endcase

        // I/Q is zero whenever no symbol is presented
        out_i_d = out_valid_d ? map_i : '0;
        out_q_d = out_valid_d ? map_q : '0;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (r) begin
            state_q     <= ST_IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            phase_q     <= PH_0;
            out_valid_q <= 1'b0;
            out_i_q     <= '0;
            out_q_q     <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            phase_q     <= phase_d;
            out_valid_q <= out_valid_d;
            out_i_q     <= out_i_d;
            out_q_q     <= out_q_d;
        end
    end

    assign in_ready  = rdy_c && !r;
    assign out_phase = phase_q;
    assign out_i     = out_i_q;
    assign out_q     = out_q_q;
    assign out_valid = out_valid_q;

endmodule
